// File: rtl/clk_ratio_gen_if.sv
// clk_ratio_gen_if: control inputs and divided-clock/sync outputs of clk_ratio_gen.
interface clk_ratio_gen_if #(parameter int CNT_W = 5);
    logic             start;
    logic             ratio_ld;
    logic [CNT_W-1:0] ratio_jbus;
    logic [CNT_W-1:0] ratio_ddr;
    logic             jbus_clk;
    logic             ddr_clk;
    logic             jbus_tx_sync;
    logic             ddr_tx_sync;
    logic             jbus_rx_sync;
    logic             ddr_rx_sync;
    logic             align;
    logic             running;
    logic             ratio_err;
    modport master (
        output start, ratio_ld, ratio_jbus, ratio_ddr,
        input  jbus_clk, ddr_clk, jbus_tx_sync, ddr_tx_sync, jbus_rx_sync, ddr_rx_sync,
               align, running, ratio_err
    );
    modport slave (
        input  start, ratio_ld, ratio_jbus, ratio_ddr,
        output jbus_clk, ddr_clk, jbus_tx_sync, ddr_tx_sync, jbus_rx_sync, ddr_rx_sync,
               align, running, ratio_err
    );
endinterface

// File: rtl/clk_ratio_gen.sv
// clk_ratio_gen: divides gclk into JBUS and DDR clock levels with sync pulses,
// glitch-free ratio changes at period boundaries and an orderly per-domain stop.
module clk_ratio_gen #(parameter int CNT_W = 5) (
    input logic           gclk,
    input logic           arst_l,
    clk_ratio_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARM, RUN, STOP} state_t;
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_jb_q, cnt_jb_d, cnt_dr_q, cnt_dr_d;
    logic [CNT_W-1:0] act_jb_q, act_jb_d, act_dr_q, act_dr_d;
    logic [CNT_W-1:0] pend_jb_q, pend_jb_d, pend_dr_q, pend_dr_d, ld_jb, ld_dr;
    logic pv_jb_q, pv_jb_d, pv_dr_q, pv_dr_d, frz_jb_q, frz_jb_d, frz_dr_q, frz_dr_d;
    logic err_q, err_d, run_q, idle_q, stopping, wrap_jb, wrap_dr, run_d, live_jb, live_dr;
    logic [7:0] out_q, out_d;

    always_comb begin
        run_q    = state_q == RUN || state_q == STOP;
        idle_q   = state_q == IDLE;
        stopping = run_q && !bus.start;
        ld_jb    = bus.ratio_jbus < CNT_W'(2) ? CNT_W'(2) : bus.ratio_jbus;
        ld_dr    = bus.ratio_ddr < CNT_W'(2) ? CNT_W'(2) : bus.ratio_ddr;
        err_d    = err_q | (bus.ratio_ld && (bus.ratio_jbus < CNT_W'(2) || bus.ratio_ddr < CNT_W'(2)));
        wrap_jb  = run_q && !frz_jb_q && cnt_jb_q == act_jb_q - CNT_W'(1);
        wrap_dr  = run_q && !frz_dr_q && cnt_dr_q == act_dr_q - CNT_W'(1);
        // a frozen domain rejoins only when the other wraps, so both restart from 0 together
        frz_jb_d = run_q && (frz_jb_q ? !(bus.start && wrap_dr) : wrap_jb && stopping);
        frz_dr_d = run_q && (frz_dr_q ? !(bus.start && wrap_jb) : wrap_dr && stopping);
        cnt_jb_d = (!run_q || frz_jb_q || wrap_jb) ? '0 : cnt_jb_q + CNT_W'(1);
        cnt_dr_d = (!run_q || frz_dr_q || wrap_dr) ? '0 : cnt_dr_q + CNT_W'(1);
        act_jb_d = idle_q ? (bus.ratio_ld ? ld_jb : pv_jb_q ? pend_jb_q : act_jb_q)
                          : (wrap_jb && pv_jb_q ? pend_jb_q : act_jb_q);
        act_dr_d = idle_q ? (bus.ratio_ld ? ld_dr : pv_dr_q ? pend_dr_q : act_dr_q)
                          : (wrap_dr && pv_dr_q ? pend_dr_q : act_dr_q);
        pend_jb_d = bus.ratio_ld && !idle_q ? ld_jb : pend_jb_q;
        pend_dr_d = bus.ratio_ld && !idle_q ? ld_dr : pend_dr_q;
        // a load coinciding with a wrap stays pending for the following wrap
        pv_jb_d  = !idle_q && (bus.ratio_ld || (pv_jb_q && !wrap_jb));
        pv_dr_d  = !idle_q && (bus.ratio_ld || (pv_dr_q && !wrap_dr));
        state_d  = idle_q ? (bus.start ? ARM : IDLE)
                 : state_q == ARM ? (bus.start ? RUN : IDLE)
                 : (frz_jb_d && frz_dr_d) ? IDLE : bus.start ? RUN : STOP;
        run_d    = state_d == RUN || state_d == STOP;
        live_jb  = run_d && !frz_jb_d;
        live_dr  = run_d && !frz_dr_d;
        out_d    = {live_jb && cnt_jb_d < (act_jb_d >> 1),
                    live_dr && cnt_dr_d < (act_dr_d >> 1),
                    live_jb && cnt_jb_d == '0,
                    live_jb && cnt_jb_d == act_jb_d - CNT_W'(1),
                    live_dr && cnt_dr_d == '0,
                    live_dr && cnt_dr_d == act_dr_d - CNT_W'(1),
                    state_d == RUN && live_jb && live_dr && cnt_jb_d == '0 && cnt_dr_d == '0,
                    run_d};
    end

    always_ff @(posedge gclk or negedge arst_l) begin
        if (!arst_l) begin
            state_q   <= IDLE;
            cnt_jb_q  <= '0;
            cnt_dr_q  <= '0;
            act_jb_q  <= CNT_W'(2);
            act_dr_q  <= CNT_W'(2);
            pend_jb_q <= CNT_W'(2);
            pend_dr_q <= CNT_W'(2);
            pv_jb_q   <= 1'b0;
            pv_dr_q   <= 1'b0;
            frz_jb_q  <= 1'b0;
            frz_dr_q  <= 1'b0;
            err_q     <= 1'b0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_jb_q  <= cnt_jb_d;
            cnt_dr_q  <= cnt_dr_d;
            act_jb_q  <= act_jb_d;
            act_dr_q  <= act_dr_d;
            pend_jb_q <= pend_jb_d;
            pend_dr_q <= pend_dr_d;
            pv_jb_q   <= pv_jb_d;
            pv_dr_q   <= pv_dr_d;
            frz_jb_q  <= frz_jb_d;
            frz_dr_q  <= frz_dr_d;
            err_q     <= err_d;
            out_q     <= out_d;
        end
    end

    assign {bus.jbus_clk, bus.ddr_clk, bus.jbus_tx_sync, bus.jbus_rx_sync,
            bus.ddr_tx_sync, bus.ddr_rx_sync, bus.align, bus.running} = out_q;
    assign bus.ratio_err = err_q;
endmodule

// File: tb/tb_clk_ratio_gen.sv
// tb_clk_ratio_gen: directed vector table plus hand-written stop/restart/reset sequences.
// Observed vector order: {jclk, dclk, jtx, jrx, dtx, drx, align, running, err}.
module tb_clk_ratio_gen;
    logic gclk = 1'b0;
    logic arst_l = 1'b0;
    int total = 0;
    int bad = 0;

    clk_ratio_gen_if #(.CNT_W(5)) bus();
    clk_ratio_gen #(.CNT_W(5)) dut (.gclk(gclk), .arst_l(arst_l), .bus(bus));

    always #5 gclk = ~gclk;

    typedef struct {
        logic       start;
        logic       ld;
        logic [4:0] rj;
        logic [4:0] rd;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[33];
    logic [8:0] obs;
    assign obs = {bus.jbus_clk, bus.ddr_clk, bus.jbus_tx_sync, bus.jbus_rx_sync,
                  bus.ddr_tx_sync, bus.ddr_rx_sync, bus.align, bus.running, bus.ratio_err};

    function automatic vec_t mk(input logic s, input logic l, input logic [4:0] j,
                                input logic [4:0] d, input logic [8:0] e);
        mk = '{start: s, ld: l, rj: j, rd: d, exp: e};
    endfunction

    task automatic chk(input string name, input logic [8:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, obs, exp);
        end
    endtask

    task automatic step(input logic s, input logic l, input logic [4:0] j, input logic [4:0] d);
        bus.start = s;
        bus.ratio_ld = l;
        bus.ratio_jbus = j;
        bus.ratio_ddr = d;
        @(posedge gclk);
        @(negedge gclk);
    endtask

    task automatic do_reset();
        bus.start = 1'b0;
        bus.ratio_ld = 1'b0;
        arst_l = 1'b0;
        @(negedge gclk);
        arst_l = 1'b1;
    endtask

    initial begin
        tbl[0]  = mk(0, 1, 4, 3, 9'b000000000);
        tbl[1]  = mk(1, 0, 0, 0, 9'b000000000);
        tbl[2]  = mk(1, 0, 0, 0, 9'b111010110);
        tbl[3]  = mk(1, 0, 0, 0, 9'b100000010);
        tbl[4]  = mk(1, 0, 0, 0, 9'b000001010);
        tbl[5]  = mk(1, 0, 0, 0, 9'b010110010);
        tbl[6]  = mk(1, 0, 0, 0, 9'b101000010);
        tbl[7]  = mk(1, 0, 0, 0, 9'b100001010);
        tbl[8]  = mk(1, 0, 0, 0, 9'b010010010);
        tbl[9]  = mk(1, 0, 0, 0, 9'b000100010);
        tbl[10] = mk(1, 0, 0, 0, 9'b101001010);
        tbl[11] = mk(1, 0, 0, 0, 9'b110010010);
        tbl[12] = mk(1, 0, 0, 0, 9'b000000010);
        tbl[13] = mk(1, 0, 0, 0, 9'b000101010);
        tbl[14] = mk(1, 0, 0, 0, 9'b111010110);
        tbl[15] = mk(1, 0, 0, 0, 9'b100000010);
        tbl[16] = mk(1, 1, 6, 3, 9'b000001010);
        tbl[17] = mk(1, 0, 0, 0, 9'b010110010);
        tbl[18] = mk(1, 0, 0, 0, 9'b101000010);
        tbl[19] = mk(1, 0, 0, 0, 9'b100001010);
        tbl[20] = mk(1, 0, 0, 0, 9'b110010010);
        tbl[21] = mk(1, 0, 0, 0, 9'b000000010);
        tbl[22] = mk(1, 0, 0, 0, 9'b000001010);
        tbl[23] = mk(1, 0, 0, 0, 9'b010110010);
        tbl[24] = mk(1, 0, 0, 0, 9'b101000010);
        tbl[25] = mk(1, 0, 0, 0, 9'b100001010);
        tbl[26] = mk(1, 0, 0, 0, 9'b110010010);
        tbl[27] = mk(1, 0, 0, 0, 9'b000000010);
        tbl[28] = mk(1, 0, 0, 0, 9'b000001010);
        tbl[29] = mk(1, 0, 0, 0, 9'b010110010);
        tbl[30] = mk(1, 1, 2, 3, 9'b101000010);
        tbl[31] = mk(1, 0, 0, 0, 9'b100001010);
        tbl[32] = mk(1, 0, 0, 0, 9'b110010010);

        bus.start = 1'b0;
        bus.ratio_ld = 1'b0;
        bus.ratio_jbus = '0;
        bus.ratio_ddr = '0;
        repeat (2) @(negedge gclk);
        chk("reset_state", 9'b000000000);
        arst_l = 1'b1;

        for (int i = 0; i < 33; i++) begin
            step(tbl[i].start, tbl[i].ld, tbl[i].rj, tbl[i].rd);
            chk($sformatf("vec%0d", i), tbl[i].exp);
        end

        #2 arst_l = 1'b0;
        #1 chk("async_reset", 9'b000000000);
        @(negedge gclk);
        bus.start = 1'b0;
        arst_l = 1'b1;
        step(1, 0, 0, 0); chk("rst_arm", 9'b000000000);
        step(1, 0, 0, 0); chk("rst_ratio2_c0", 9'b111010110);
        step(1, 0, 0, 0); chk("rst_ratio2_c1", 9'b000101010);

        do_reset();
        step(0, 1, 5, 1); chk("illegal_load", 9'b000000001);
        step(1, 0, 0, 0); chk("stop_arm", 9'b000000001);
        step(1, 0, 0, 0); chk("stop_c0", 9'b111010111);
        step(1, 0, 0, 0); chk("stop_c1", 9'b100001011);
        step(0, 0, 0, 0); chk("stop_ddr_frozen", 9'b000000011);
        step(0, 0, 0, 0); chk("stop_j3", 9'b000000011);
        step(0, 0, 0, 0); chk("stop_j4", 9'b000100011);
        step(0, 0, 0, 0); chk("stop_idle", 9'b000000001);
        step(0, 0, 0, 0); chk("err_sticky", 9'b000000001);
        #2 arst_l = 1'b0;
        #1 chk("err_cleared", 9'b000000000);
        @(negedge gclk);
        arst_l = 1'b1;

        step(0, 1, 5, 2); chk("rs_load", 9'b000000000);
        step(1, 0, 0, 0); chk("rs_arm", 9'b000000000);
        step(0, 0, 0, 0); chk("rs_arm_abort", 9'b000000000);
        step(1, 0, 0, 0); chk("rs_arm2", 9'b000000000);
        step(1, 0, 0, 0); chk("rs_c0", 9'b111010110);
        step(1, 0, 0, 0); chk("rs_c1", 9'b100001010);
        step(0, 0, 0, 0); chk("rs_ddr_frozen", 9'b000000010);
        step(1, 0, 0, 0); chk("rs_resume_j3", 9'b000000010);
        step(1, 0, 0, 0); chk("rs_resume_j4", 9'b000100010);
        step(1, 0, 0, 0); chk("rs_rejoin", 9'b111010110);
        step(1, 0, 0, 0); chk("rs_rejoin_c1", 9'b100001010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
